// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the DATA_MEM two-port arbiter.
package dmem_arbiter_pkg;

  localparam int D_WIDTH_DEF    = 32;
  localparam int ADDR_WIDTH_DEF = 5;
  localparam int NUM_PORTS      = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // One-hot response vector for a granted port id.
  function automatic logic [NUM_PORTS-1:0] port_onehot(input logic port);
    logic [NUM_PORTS-1:0] vec;
    if (port) begin
      vec = 2'b10;
    end else begin
      vec = 2'b01;
    end
    return vec;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester wins outright, and on a
// tie the port that was not granted last time wins.
module rr_arb2
  import dmem_arbiter_pkg::*;
(
  input  logic [NUM_PORTS-1:0] valid,
  input  logic                 last_grant,
  output logic [NUM_PORTS-1:0] grant
);

  // Pick at most one requester, alternating on ties.
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01: grant = 2'b01;
      2'b10: grant = 2'b10;
      2'b11: begin
        if (last_grant) begin
          grant = 2'b01;
        end else begin
          grant = 2'b10;
        end
      end
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port DATA_MEM between the core LSU (port 0) and a
// debug/DMA master (port 1). One access at a time: IDLE -> ACCESS -> RESP.
// Optional feature: define DMEM_ARBITER_RANGE_CHECK_EN to reject addresses
// >= MEM_WORDS (no memory strobe, error response with zero data).
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int D_WIDTH    = D_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int MEM_WORDS  = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NUM_PORTS-1:0]  i_req_valid,
  output logic [NUM_PORTS-1:0]  o_req_ready,
  input  logic [NUM_PORTS-1:0]  i_req_we,
  input  logic [ADDR_WIDTH-1:0] i_req_addr0,
  input  logic [ADDR_WIDTH-1:0] i_req_addr1,
  input  logic [D_WIDTH-1:0]    i_req_wdata0,
  input  logic [D_WIDTH-1:0]    i_req_wdata1,
  output logic [NUM_PORTS-1:0]  o_rsp_valid,
  output logic [D_WIDTH-1:0]    o_rsp_rdata,
  output logic                  o_rsp_err,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_write,
  output logic                  o_mem_read,
  output logic [D_WIDTH-1:0]    o_mem_wdata,
  input  logic [D_WIDTH-1:0]    i_mem_rdata
);

  state_t                state_r;
  logic                  last_grant_r;
  logic                  port_r;
  logic                  we_r;
  logic                  bad_r;

  logic [NUM_PORTS-1:0]  grant_s;
  logic                  sel_port_s;
  logic                  sel_we_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [D_WIDTH-1:0]    sel_wdata_s;
  logic                  bad_s;

  rr_arb2 u_rr_arb2 (
    .valid      (i_req_valid),
    .last_grant (last_grant_r),
    .grant      (grant_s)
  );

  // Ready is offered only while idle, to the arbitration winner.
  assign o_req_ready = (state_r == IDLE) ? grant_s : 2'b00;

  // Route the winning port's request fields toward the latches.
  always_comb begin
    sel_port_s  = 1'b0;
    sel_we_s    = 1'b0;
    sel_addr_s  = {ADDR_WIDTH{1'b0}};
    sel_wdata_s = {D_WIDTH{1'b0}};
    if (grant_s[1]) begin
      sel_port_s  = 1'b1;
      sel_we_s    = i_req_we[1];
      sel_addr_s  = i_req_addr1;
      sel_wdata_s = i_req_wdata1;
    end else begin
      sel_port_s  = 1'b0;
      sel_we_s    = i_req_we[0];
      sel_addr_s  = i_req_addr0;
      sel_wdata_s = i_req_wdata0;
    end
  end

`ifdef DMEM_ARBITER_RANGE_CHECK_EN
  localparam logic [31:0] MEM_WORDS_U = 32'(MEM_WORDS);

  // Addresses beyond the implemented words never reach DATA_MEM.
  assign bad_s = (32'(sel_addr_s) >= MEM_WORDS_U);

  // Error flag is captured with the response and held until the next one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rsp_err <= 1'b0;
    end else if (state_r == ACCESS) begin
      o_rsp_err <= bad_r;
    end else begin
      o_rsp_err <= o_rsp_err;
    end
  end
`else
  assign bad_s     = 1'b0;
  assign o_rsp_err = 1'b0;
`endif

  // Transaction FSM: latch at accept, strobe DATA_MEM for one cycle, respond.
  // Strobes are flops set on the accept edge so they are high exactly
  // during ACCESS and drop asynchronously on reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      port_r       <= 1'b0;
      we_r         <= 1'b0;
      bad_r        <= 1'b0;
      o_mem_addr   <= {ADDR_WIDTH{1'b0}};
      o_mem_wdata  <= {D_WIDTH{1'b0}};
      o_mem_write  <= 1'b0;
      o_mem_read   <= 1'b0;
      o_rsp_valid  <= 2'b00;
      o_rsp_rdata  <= {D_WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          o_rsp_valid <= 2'b00;
          if (grant_s != 2'b00) begin
            port_r       <= sel_port_s;
            we_r         <= sel_we_s;
            bad_r        <= bad_s;
            last_grant_r <= sel_port_s;
            o_mem_addr   <= sel_addr_s;
            o_mem_wdata  <= sel_wdata_s;
            o_mem_write  <= sel_we_s & ~bad_s;
            o_mem_read   <= ~sel_we_s & ~bad_s;
            state_r      <= ACCESS;
          end else begin
            o_mem_write <= 1'b0;
            o_mem_read  <= 1'b0;
            state_r     <= IDLE;
          end
        end
        ACCESS: begin
          o_mem_write <= 1'b0;
          o_mem_read  <= 1'b0;
          if (we_r || bad_r) begin
            o_rsp_rdata <= {D_WIDTH{1'b0}};
          end else begin
            o_rsp_rdata <= i_mem_rdata;
          end
          o_rsp_valid <= port_onehot(port_r);
          state_r     <= RESP;
        end
        RESP: begin
          o_rsp_valid <= 2'b00;
          state_r     <= IDLE;
        end
        default: begin
          o_mem_write <= 1'b0;
          o_mem_read  <= 1'b0;
          o_rsp_valid <= 2'b00;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural DATA_MEM.
module tb_dmem_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [1:0]  i_req_valid;
  logic [1:0]  o_req_ready;
  logic [1:0]  i_req_we;
  logic [4:0]  i_req_addr0, i_req_addr1;
  logic [31:0] i_req_wdata0, i_req_wdata1;
  logic [1:0]  o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic [4:0]  o_mem_addr;
  logic        o_mem_write, o_mem_read;
  logic [31:0] o_mem_wdata;
  logic [31:0] i_mem_rdata;

  int checks = 0;
  int failures = 0;
  int grants = 0;

  // DATA_MEM model: unwritten words read as 0xA000 + address.
  logic [31:0] mem [0:31];
  logic [31:0] written = 32'd0;

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    if (o_mem_write) begin
      mem[o_mem_addr]     <= o_mem_wdata;
      written[o_mem_addr] <= 1'b1;
    end
  end

  assign i_mem_rdata = written[o_mem_addr] ? mem[o_mem_addr]
                                           : (32'hA000 + {27'd0, o_mem_addr});

  dmem_arbiter #(.D_WIDTH(32), .ADDR_WIDTH(5), .MEM_WORDS(20)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_we     (i_req_we),
    .i_req_addr0  (i_req_addr0),
    .i_req_addr1  (i_req_addr1),
    .i_req_wdata0 (i_req_wdata0),
    .i_req_wdata1 (i_req_wdata1),
    .o_rsp_valid  (o_rsp_valid),
    .o_rsp_rdata  (o_rsp_rdata),
    .o_rsp_err    (o_rsp_err),
    .o_mem_addr   (o_mem_addr),
    .o_mem_write  (o_mem_write),
    .o_mem_read   (o_mem_read),
    .o_mem_wdata  (o_mem_wdata),
    .i_mem_rdata  (i_mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // One isolated transaction on port p, checked through all three states.
  task automatic do_xact(input int p, input logic we, input logic [4:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata);
    logic [1:0] oh;
    oh = (p == 1) ? 2'b10 : 2'b01;
    if (p == 1) begin
      i_req_addr1 = addr; i_req_wdata1 = wdata; i_req_we[1] = we;
    end else begin
      i_req_addr0 = addr; i_req_wdata0 = wdata; i_req_we[0] = we;
    end
    i_req_valid = oh;
    #1;
    chk("xact_ready", {30'd0, o_req_ready}, {30'd0, oh});
    tick();
    i_req_valid = 2'b00;
    chk("xact_access_write", {31'd0, o_mem_write}, {31'd0, we});
    chk("xact_access_read", {31'd0, o_mem_read}, {31'd0, ~we});
    chk("xact_access_addr", {27'd0, o_mem_addr}, {27'd0, addr});
    chk("xact_access_ready", {30'd0, o_req_ready}, 32'd0);
    tick();
    chk("xact_rsp_valid", {30'd0, o_rsp_valid}, {30'd0, oh});
    chk("xact_rsp_rdata", o_rsp_rdata, exp_rdata);
    chk("xact_rsp_err", {31'd0, o_rsp_err}, 32'd0);
    tick();
    chk("xact_rsp_done", {30'd0, o_rsp_valid}, 32'd0);
  endtask

  initial begin
    i_rst_n      = 1'b0;
    i_req_valid  = 2'b00;
    i_req_we     = 2'b00;
    i_req_addr0  = 5'd0;
    i_req_addr1  = 5'd0;
    i_req_wdata0 = 32'd0;
    i_req_wdata1 = 32'd0;
    #12;
    // Reset state
    chk("rst_ready", {30'd0, o_req_ready}, 32'd0);
    chk("rst_rsp_valid", {30'd0, o_rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", o_rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'd0, o_rsp_err}, 32'd0);
    chk("rst_mem_strobes", {30'd0, o_mem_write, o_mem_read}, 32'd0);
    chk("rst_mem_addr", {27'd0, o_mem_addr}, 32'd0);
    chk("rst_mem_wdata", o_mem_wdata, 32'd0);
    tick();
    i_rst_n = 1'b1;
    tick();

    // Port 0 write then read of address 0
    do_xact(0, 1'b1, 5'd0, 32'd45, 32'd0);
    chk("t1_wdata_mem", mem[0], 32'd45);
    do_xact(0, 1'b0, 5'd0, 32'd0, 32'd45);

    // Fresh reset so port 0 wins the first tie
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    tick();

    // Simultaneous writes: port 0 first, port 1 right after port 0's RESP
    i_req_we     = 2'b11;
    i_req_addr0  = 5'd1; i_req_wdata0 = 32'd55;
    i_req_addr1  = 5'd2; i_req_wdata1 = 32'd560;
    i_req_valid  = 2'b11;
    #1;
    chk("t2_ready_first", {30'd0, o_req_ready}, 32'd1);
    tick();
    i_req_valid = 2'b10;
    chk("t2_p0_write", {31'd0, o_mem_write}, 32'd1);
    chk("t2_p0_addr", {27'd0, o_mem_addr}, 32'd1);
    chk("t2_busy_ready", {30'd0, o_req_ready}, 32'd0);
    tick();
    chk("t2_p0_rsp", {30'd0, o_rsp_valid}, 32'd1);
    chk("t2_resp_ready", {30'd0, o_req_ready}, 32'd0);
    tick();
    chk("t2_ready_second", {30'd0, o_req_ready}, 32'd2);
    tick();
    i_req_valid = 2'b00;
    chk("t2_p1_write", {31'd0, o_mem_write}, 32'd1);
    chk("t2_p1_addr", {27'd0, o_mem_addr}, 32'd2);
    chk("t2_p1_wdata", o_mem_wdata, 32'd560);
    tick();
    chk("t2_p1_rsp", {30'd0, o_rsp_valid}, 32'd2);
    tick();
    do_xact(0, 1'b0, 5'd1, 32'd0, 32'd55);
    do_xact(1, 1'b0, 5'd2, 32'd0, 32'd560);

    // Both ports held valid with reads: alternate grants 0,1,0,1
    i_req_we    = 2'b00;
    i_req_addr0 = 5'd1;
    i_req_addr1 = 5'd2;
    i_req_valid = 2'b11;
    #1;
    for (int i = 0; i < 12; i++) begin
      logic [1:0] exp_oh;
      exp_oh = ((i / 3) % 2 == 0) ? 2'b01 : 2'b10;
      if (o_req_ready != 2'b00) grants++;
      if (i % 3 == 0) begin
        chk("t3_ready_idle", {30'd0, o_req_ready}, {30'd0, exp_oh});
      end else begin
        chk("t3_ready_busy", {30'd0, o_req_ready}, 32'd0);
      end
      if (i % 3 == 2) begin
        chk("t3_rsp_valid", {30'd0, o_rsp_valid}, {30'd0, exp_oh});
        chk("t3_rsp_rdata", o_rsp_rdata, (exp_oh == 2'b01) ? 32'd55 : 32'd560);
      end else begin
        chk("t3_rsp_quiet", {30'd0, o_rsp_valid}, 32'd0);
      end
      tick();
    end
    i_req_valid = 2'b00;
    chk("t3_grant_count", grants, 32'd4);

    // Reset in the middle of a port 1 write to address 3
    i_req_we[1] = 1'b1; i_req_addr1 = 5'd3; i_req_wdata1 = 32'd567;
    i_req_valid = 2'b10;
    tick();
    i_req_valid = 2'b00;
    chk("t4_access_write", {31'd0, o_mem_write}, 32'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("t4_abort_write", {31'd0, o_mem_write}, 32'd0);
    chk("t4_abort_read", {31'd0, o_mem_read}, 32'd0);
    chk("t4_abort_rsp", {30'd0, o_rsp_valid}, 32'd0);
    tick();
    chk("t4_abort_rsp_edge", {30'd0, o_rsp_valid}, 32'd0);
    i_rst_n = 1'b1;
    tick();
    chk("t4_after_rsp", {30'd0, o_rsp_valid}, 32'd0);
    do_xact(0, 1'b0, 5'd3, 32'd0, 32'hA003);

`ifdef DMEM_ARBITER_RANGE_CHECK_EN
    // Out-of-range write is suppressed and flagged
    i_req_we[0] = 1'b1; i_req_addr0 = 5'd25; i_req_wdata0 = 32'd99;
    i_req_valid = 2'b01;
    tick();
    i_req_valid = 2'b00;
    chk("t5_bad_write", {31'd0, o_mem_write}, 32'd0);
    chk("t5_bad_read", {31'd0, o_mem_read}, 32'd0);
    tick();
    chk("t5_bad_rsp", {30'd0, o_rsp_valid}, 32'd1);
    chk("t5_bad_err", {31'd0, o_rsp_err}, 32'd1);
    chk("t5_bad_rdata", o_rsp_rdata, 32'd0);
    tick();
    do_xact(0, 1'b1, 5'd19, 32'd1919, 32'd0);
    do_xact(0, 1'b0, 5'd19, 32'd0, 32'd1919);
`endif

    // Quiet bus with no requests
    for (int i = 0; i < 10; i++) begin
      chk("t6_idle_strobes", {30'd0, o_mem_write, o_mem_read}, 32'd0);
      chk("t6_idle_ready", {30'd0, o_req_ready}, 32'd0);
      chk("t6_idle_rsp", {30'd0, o_rsp_valid}, 32'd0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port DATA_MEM between two requesters: port 0 is the core load/store unit and port 1 is a debug/DMA master.
- Arbitrates round-robin and runs one memory access at a time through a 3-state FSM.
- Drives the DATA_MEM strobes (address, write, read, data) and returns a registered response to the granted requester.
- Sits between the requesters and DATA_MEM in the top level.

Parameters:
- D_WIDTH, 32, data width in bits; matches DATA_MEM.
- ADDR_WIDTH, 5, word address width; matches DATA_MEM.
- MEM_WORDS, 32, number of implemented words; used only by the optional range check.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_req_valid  in  2  per-port request valid; bit k belongs to port k.
- o_req_ready  out  2  per-port request accept; one-hot or zero.
- i_req_we  in  2  per-port write enable: 1 = write, 0 = read.
- i_req_addr0, i_req_addr1  in  ADDR_WIDTH  per-port word address.
- i_req_wdata0, i_req_wdata1  in  D_WIDTH  per-port write data.
- o_rsp_valid  out  2  per-port response pulse, one cycle.
- o_rsp_rdata  out  D_WIDTH  read data; shared by both ports, qualified by o_rsp_valid.
- o_rsp_err  out  1  error flag, qualified by o_rsp_valid (optional feature only).
- o_mem_addr  out  ADDR_WIDTH  to DATA_MEM address.
- o_mem_write  out  1  to DATA_MEM write strobe.
- o_mem_read  out  1  to DATA_MEM read strobe.
- o_mem_wdata  out  D_WIDTH  to DATA_MEM write data.
- i_mem_rdata  in  D_WIDTH  from DATA_MEM read data.

Behaviour:
- Reset values: state=IDLE, last_grant=1 (so port 0 wins the first tie), and all outputs 0, i.e. o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_mem_*.
- DATA_MEM contract: a write commits on the rising edge that ends a cycle with o_mem_write=1. Read data on i_mem_rdata is valid within the cycle o_mem_read=1 and is sampled at the end of that cycle.
- State IDLE:
  - o_req_ready is combinational, asserted only in IDLE.
  - One valid → that port gets ready. Both valid → the port != last_grant gets ready. None valid → ready=0.
  - Handshake is valid&&ready at the rising edge. At that edge, latch port id, we, addr and wdata; set last_grant=port; go to ACCESS.
- State ACCESS (exactly 1 cycle):
  - Drive o_mem_addr and o_mem_wdata from the latched values; o_mem_write=we, o_mem_read=!we.
  - At the end of the cycle, register o_rsp_rdata = we ? 0 : i_mem_rdata; go to RESP.
  - Outside ACCESS, o_mem_write=o_mem_read=0. o_mem_addr and o_mem_wdata hold their last values.
- State RESP (exactly 1 cycle): o_rsp_valid[port]=1; go to IDLE. o_rsp_rdata holds until the next RESP.
- Latency: accept edge → ACCESS on cycle +1 → response on cycle +2.
- Throughput: one transaction per 3 cycles. A request held valid is re-arbitrated in the cycle after RESP.
- Requester rule: a requester holds valid, we, addr and wdata stable until accepted. The arbiter never drops a held valid.
- Fairness: with both ports continuously valid, grants alternate 0,1,0,1…
- Address: no wrap or arithmetic; passed through unchanged.
- Reset mid-operation:
  - Async reset forces IDLE and deasserts all strobes immediately.
  - A write interrupted in ACCESS before its edge is not committed.
  - No response is issued for an aborted transaction.

Optional Feature:
- Macro DMEM_ARBITER_RANGE_CHECK_EN.
- Defined: in IDLE at accept, latched addr >= MEM_WORDS marks the transaction bad.
  - In ACCESS, o_mem_write and o_mem_read stay 0.
  - RESP gives o_rsp_err=1 and o_rsp_rdata=0.
  - Good transactions give o_rsp_err=0.
- Undefined: no comparator; o_rsp_err is tied to 0; every address is forwarded.

Decomposition:
- Package dmem_arbiter_pkg holds:
  - D_WIDTH and ADDR_WIDTH default constants.
  - NUM_PORTS=2.
  - The state encoding IDLE=2'd0, ACCESS=2'd1, RESP=2'd2 as a typedef.
- Sub-module rr_arb2: combinational 2-way round-robin picker. Inputs are valid[1:0] and last_grant; output is grant[1:0], one-hot or zero.
- The FSM, latches and memory drive stay in dmem_arbiter.

Test Plan:
- Port 0 write addr 5'd0 data 45, then port 0 read addr 0 → first: o_mem_write=1 in ACCESS and rsp_valid[0] 2 cycles after accept with rdata 0. Second: rsp_rdata=45.
- Both ports valid at the same time: port 0 write addr 1 data 55, port 1 write addr 2 data 560 → port 0 granted first, port 1 accepted the cycle after port 0's RESP. Reads of addr 1 and addr 2 then return 55 and 560.
- Both ports held valid with reads for 12 cycles → exactly 4 grants in order 0,1,0,1. Ready is never asserted outside IDLE.
- Port 1 write addr 3 data 567, with i_rst_n pulled low mid-ACCESS → strobes drop within the cycle and no rsp_valid is issued. After reset release, a read of addr 3 returns its old value.
- With DMEM_ARBITER_RANGE_CHECK_EN and MEM_WORDS=20: write addr 5'd25 → no memory strobe, o_rsp_err=1 and rdata 0. Write addr 5'd19 → normal commit with err=0.
- Idle with no valids for 10 cycles → o_mem_read and o_mem_write stay 0; o_req_ready and o_rsp_valid stay 0.
